branch_pred_unit: RTL and testbench



---
 rtl/bpu_pkg.sv | 19 +
 rtl/bpu_btb.sv | 60 ++++++
 rtl/branch_pred_unit.sv | 92 +++++++++
 tb/tb_branch_pred_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: 2-bit counter encodings
// and the saturating counter update.
package bpu_pkg;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    // Move one step toward the resolved outcome, sticking at either end.
    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: combinational tag-compare read port and
// one write port. Only the valid bits are reset.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] rd_pc,
    output logic                 rd_hit,
    output logic [WORD_SIZE-1:0] rd_target,
    output logic                 rd_jmp,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] wr_pc,
    input  logic [WORD_SIZE-1:0] wr_target,
    input  logic                 wr_jmp
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam int TAG_W = WORD_SIZE - IDX_BITS;

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     jmp_mem;
    logic [TAG_W-1:0]     tag_mem    [DEPTH];
    logic [WORD_SIZE-1:0] target_mem [DEPTH];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [TAG_W-1:0]    wr_tag;

    assign rd_idx = rd_pc[IDX_BITS-1:0];
    assign rd_tag = rd_pc[WORD_SIZE-1:IDX_BITS];
    assign wr_idx = wr_pc[IDX_BITS-1:0];
    assign wr_tag = wr_pc[WORD_SIZE-1:IDX_BITS];

    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = target_mem[rd_idx];
    assign rd_jmp    = jmp_mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    // NOTE: payload arrays carry no reset; a cleared valid bit already masks
    // them, and leaving them unreset lets synthesis map them to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            jmp_mem[wr_idx]    <= wr_jmp;
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch predictor: BTB + PHT of 2-bit counters + mispredict counter.
// Define BPU_GSHARE_EN for gshare indexing (PC XOR global history); default is bimodal.
module branch_pred_unit
    import bpu_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_BITS = 6,
    parameter int PHT_IDX_BITS = 4,
    parameter int CNT_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [WORD_SIZE-1:0]    if_pc,
    output logic                    pred_hit,
    output logic                    pred_taken,
    output logic [WORD_SIZE-1:0]    pred_next_pc,
    output logic [PHT_IDX_BITS-1:0] pred_idx,
    input  logic                    upd_valid,
    input  logic                    upd_is_jump,
    input  logic [WORD_SIZE-1:0]    upd_pc,
    input  logic                    upd_taken,
    input  logic [WORD_SIZE-1:0]    upd_target,
    input  logic [PHT_IDX_BITS-1:0] upd_idx,
    input  logic                    upd_mispredict,
    output logic [CNT_BITS-1:0]     miss_cnt
);

    localparam int PHT_DEPTH = 1 << PHT_IDX_BITS;

    logic [1:0]           pht [PHT_DEPTH];
    logic                 upd_fire;
    logic                 btb_jmp;
    logic [WORD_SIZE-1:0] btb_target;
    logic [1:0]           pht_ctr;

    assign upd_fire = en && upd_valid;

    bpu_btb #(
        .WORD_SIZE (WORD_SIZE),
        .IDX_BITS  (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (if_pc),
        .rd_hit    (pred_hit),
        .rd_target (btb_target),
        .rd_jmp    (btb_jmp),
        .wr_en     (upd_fire && upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target),
        .wr_jmp    (upd_is_jump)
    );

`ifdef BPU_GSHARE_EN
    logic [PHT_IDX_BITS-1:0] ghr;

    assign pred_idx = if_pc[PHT_IDX_BITS-1:0] ^ ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (upd_fire && !upd_is_jump)
            ghr <= {ghr[PHT_IDX_BITS-2:0], upd_taken};
    end
`else
    assign pred_idx = if_pc[PHT_IDX_BITS-1:0];
`endif

    assign pht_ctr      = pht[pred_idx];
    assign pred_taken   = pred_hit && (btb_jmp || pht_ctr[1]);
    assign pred_next_pc = pred_taken ? btb_target : if_pc + WORD_SIZE'(1);

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values; lookup therefore sees no same-cycle bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                pht[i] <= CNT_RESET;
        end else if (upd_fire && !upd_is_jump) begin
            pht[upd_idx] <= cnt_update(pht[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miss_cnt <= '0;
        else if (upd_fire && upd_mispredict && (miss_cnt != '1))
            miss_cnt <= miss_cnt + CNT_BITS'(1);
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed self-checking bench for branch_pred_unit (default parameters).
// Expectations follow the bimodal build unless BPU_GSHARE_EN is defined.
module tb_branch_pred_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_next_pc;
    logic [3:0]  pred_idx;
    logic        upd_valid;
    logic        upd_is_jump;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [3:0]  upd_idx;
    logic        upd_mispredict;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_pred_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_is_jump    (upd_is_jump),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_idx        (upd_idx),
        .upd_mispredict (upd_mispredict),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a fetch PC half a cycle away from the active edge.
    task automatic look(input logic [15:0] pc);
        @(negedge clk);
        if_pc = pc;
        #1;
    endtask

    // One enabled update edge; upd_valid drops again right after the edge.
    task automatic upd(input logic jump, input logic [15:0] pc, input logic taken,
                       input logic [15:0] tgt, input logic [3:0] idx, input logic mp);
        en             = 1'b1;
        upd_valid      = 1'b1;
        upd_is_jump    = jump;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_idx        = idx;
        upd_mispredict = mp;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; if_pc = 16'h0000;
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = 16'h0000; upd_taken = 1'b0;
        upd_target = 16'h0000; upd_idx = 4'h0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        look(16'h0010);
        check("rst_hit", 32'(pred_hit), 32'd0);
        check("rst_taken", 32'(pred_taken), 32'd0);
        check("rst_next", 32'(pred_next_pc), 32'h0011);
        check("rst_idx", 32'(pred_idx), 32'h0);
        check("rst_miss", 32'(miss_cnt), 32'd0);

        // Install 0x0010 -> 0x0020; lookup before the edge sees the old state
        en = 1'b1; upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 16'h0010;
        upd_taken = 1'b1; upd_target = 16'h0020; upd_idx = 4'h0; upd_mispredict = 1'b1;
        #1;
        check("nobypass_hit", 32'(pred_hit), 32'd0);
        @(posedge clk);
        #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
        look(16'h0010);
        check("inst_hit", 32'(pred_hit), 32'd1);
        check("inst_miss", 32'(miss_cnt), 32'd1);
`ifdef BPU_GSHARE_EN
        check("inst_idx", 32'(pred_idx), 32'h1);
        check("inst_taken", 32'(pred_taken), 32'd0);
        check("inst_next", 32'(pred_next_pc), 32'h0011);
`else
        check("inst_idx", 32'(pred_idx), 32'h0);
        check("inst_taken", 32'(pred_taken), 32'd1);
        check("inst_next", 32'(pred_next_pc), 32'h0020);
`endif

        // Not-taken outcome keeps the entry and weakens PHT[0] back to 01
        upd(1'b0, 16'h0010, 1'b0, 16'h0999, 4'h0, 1'b0);
        look(16'h0010);
        check("nt_hit", 32'(pred_hit), 32'd1);
        check("nt_taken", 32'(pred_taken), 32'd0);
        check("nt_next", 32'(pred_next_pc), 32'h0011);
`ifdef BPU_GSHARE_EN
        check("nt_idx", 32'(pred_idx), 32'h2);
`endif

        // Jump install: taken regardless of PHT, PHT/GHR untouched
        upd(1'b1, 16'h0040, 1'b1, 16'h0100, 4'h0, 1'b0);
        look(16'h0040);
        check("jmp_hit", 32'(pred_hit), 32'd1);
        check("jmp_taken", 32'(pred_taken), 32'd1);
        check("jmp_next", 32'(pred_next_pc), 32'h0100);
        look(16'h0010);
        check("jmp_pht_keep", 32'(pred_taken), 32'd0);
`ifdef BPU_GSHARE_EN
        check("jmp_ghr_keep", 32'(pred_idx), 32'h2);
`endif

        // PHT[3] saturation: 01 -> 11 (sticks), then down to 00 (sticks)
        for (int i = 0; i < 5; i++)
            upd(1'b0, 16'h0003, 1'b1, 16'h0200, 4'h3, 1'b0);
        look(16'h0003);
        check("sat_hi_hit", 32'(pred_hit), 32'd1);
`ifndef BPU_GSHARE_EN
        check("sat_hi_taken", 32'(pred_taken), 32'd1);
        check("sat_hi_next", 32'(pred_next_pc), 32'h0200);
`endif
        upd(1'b0, 16'h0003, 1'b0, 16'h0000, 4'h3, 1'b0);
`ifndef BPU_GSHARE_EN
        look(16'h0003);
        check("sat_hi_stuck", 32'(pred_taken), 32'd1);
`endif
        for (int i = 0; i < 4; i++)
            upd(1'b0, 16'h0003, 1'b0, 16'h0000, 4'h3, 1'b0);
        upd(1'b0, 16'h0003, 1'b1, 16'h0200, 4'h3, 1'b0);
`ifndef BPU_GSHARE_EN
        look(16'h0003);
        check("sat_lo_stuck", 32'(pred_taken), 32'd0);
`endif
        upd(1'b0, 16'h0003, 1'b1, 16'h0200, 4'h3, 1'b0);
`ifndef BPU_GSHARE_EN
        look(16'h0003);
        check("sat_lo_recover", 32'(pred_taken), 32'd1);
`endif

        // Aliasing on BTB index 0x10
        upd(1'b1, 16'h0050, 1'b1, 16'h0123, 4'h0, 1'b0);
        look(16'h0050);
        check("alias_a_hit", 32'(pred_hit), 32'd1);
        check("alias_a_next", 32'(pred_next_pc), 32'h0123);
        look(16'h0090);
        check("alias_b_miss", 32'(pred_hit), 32'd0);
        look(16'h0010);
        check("alias_old_gone", 32'(pred_hit), 32'd0);
        upd(1'b1, 16'h0090, 1'b1, 16'h0456, 4'h0, 1'b0);
        look(16'h0050);
        check("alias_a_evicted", 32'(pred_hit), 32'd0);
        look(16'h0090);
        check("alias_b_hit", 32'(pred_hit), 32'd1);
        check("alias_b_next", 32'(pred_next_pc), 32'h0456);

        // Stall: en=0 blocks BTB, PHT and counter; lookup still follows if_pc
        en = 1'b0; upd_valid = 1'b1; upd_mispredict = 1'b1; upd_is_jump = 1'b0;
        upd_pc = 16'h0003; upd_idx = 4'h3; upd_taken = 1'b1; upd_target = 16'h0777;
        @(posedge clk);
        #1 upd_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
        look(16'h0003);
        check("stall_hit", 32'(pred_hit), 32'd1);
        check("stall_miss", 32'(miss_cnt), 32'd1);
`ifndef BPU_GSHARE_EN
        check("stall_taken", 32'(pred_taken), 32'd1);
        check("stall_next", 32'(pred_next_pc), 32'h0200);
`endif
        look(16'h0123);
        check("stall_track", 32'(pred_next_pc), 32'h0124);

        // upd_mispredict without upd_valid is ignored
        en = 1'b1; upd_valid = 1'b0; upd_mispredict = 1'b1;
        @(posedge clk);
        #1 upd_mispredict = 1'b0;
        check("mp_novalid", 32'(miss_cnt), 32'd1);

        // Counter saturation using state-neutral not-taken jump updates
        en = 1'b1; upd_valid = 1'b1; upd_is_jump = 1'b1; upd_taken = 1'b0; upd_mispredict = 1'b1;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        check("cnt_fffe", 32'(miss_cnt), 32'h0000FFFE);
        repeat (3) @(posedge clk);
        #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
        check("cnt_sat", 32'(miss_cnt), 32'h0000FFFF);

        // Async reset between edges with an update pending
        look(16'h0003);
        upd_valid = 1'b1; upd_is_jump = 1'b0; upd_taken = 1'b1; upd_mispredict = 1'b1;
        upd_pc = 16'h0003; upd_target = 16'h0200; upd_idx = 4'h3;
        #1 reset = 1'b1;
        #1;
        check("arst_hit", 32'(pred_hit), 32'd0);
        check("arst_taken", 32'(pred_taken), 32'd0);
        check("arst_next", 32'(pred_next_pc), 32'h0004);
        check("arst_idx", 32'(pred_idx), 32'h3);
        check("arst_miss", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        look(16'hFFFF);
        check("wrap_next", 32'(pred_next_pc), 32'h0000);
        check("wrap_hit", 32'(pred_hit), 32'd0);
        look(16'h0090);
        check("arst_btb_clear", 32'(pred_hit), 32'd0);

        // PHT came back as 01: one taken update yields 10 in bimodal
        upd(1'b0, 16'h0003, 1'b1, 16'h0200, 4'h3, 1'b0);
        look(16'h0003);
        check("arst_reinst_hit", 32'(pred_hit), 32'd1);
`ifdef BPU_GSHARE_EN
        check("arst_pht", 32'(pred_taken), 32'd0);
`else
        check("arst_pht", 32'(pred_taken), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
